// File: rtl/pc_next_unit_if.sv
// Bus between the PC stage and its surroundings: select/stall inputs in,
// program counter, link address and status flags out.
interface pc_next_unit_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 stall;
  logic                 branch_eq;
  logic                 branch_ne;
  logic                 zero;
  logic                 jump;
  logic                 jump_reg;
  logic [WIDTH-1:0]     branch_offset;
  logic [25:0]          jump_index;
  logic [WIDTH-1:0]     jump_reg_target;
  logic [WIDTH-1:0]     pc;
  logic [WIDTH-1:0]     pc_plus4;
  logic                 redirect;
  logic                 misalign_err;
  logic [CNT_WIDTH-1:0] redirect_count;

  modport master (
    output stall, branch_eq, branch_ne, zero, jump, jump_reg,
           branch_offset, jump_index, jump_reg_target,
    input  pc, pc_plus4, redirect, misalign_err, redirect_count
  );

  modport slave (
    input  stall, branch_eq, branch_ne, zero, jump, jump_reg,
           branch_offset, jump_index, jump_reg_target,
    output pc, pc_plus4, redirect, misalign_err, redirect_count
  );
endinterface

// File: rtl/pc_next_unit.sv
// Registered program counter with prioritised next-PC select
// (jump_reg > jump > taken branch > sequential), stall hold and status.
module pc_next_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               CNT_WIDTH    = 16
) (
  input  logic                clk,
  input  logic                reset,
  pc_next_unit_if.slave       bus
);

  logic [WIDTH-1:0]     pc_q, pc_d;
  logic                 redirect_q, redirect_d;
  logic                 misalign_q, misalign_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0]     pc_plus4;
  logic [WIDTH-1:0]     br_tgt;
  logic [WIDTH-1:0]     j_tgt;
  logic [WIDTH-1:0]     sel_tgt;
  logic                 take_br;
  logic                 non_seq;
  logic                 jr_misaligned;

  assign pc_plus4 = pc_q + WIDTH'(4);
  assign take_br  = (bus.branch_eq & bus.zero) | (bus.branch_ne & ~bus.zero);
  assign br_tgt   = pc_plus4 + (bus.branch_offset << 2);

  // Jump keeps the upper PC bits only when the address is wider than the index.
  generate
    if (WIDTH > 28) begin : g_j_region
      assign j_tgt = {pc_plus4[WIDTH-1:28], bus.jump_index, 2'b00};
    end else begin : g_j_flat
      assign j_tgt = {bus.jump_index, 2'b00};
    end
  endgenerate

  always_comb begin
    sel_tgt       = pc_plus4;
    non_seq       = 1'b0;
    jr_misaligned = 1'b0;
    if (bus.jump_reg) begin
      sel_tgt       = bus.jump_reg_target;
      non_seq       = 1'b1;
      jr_misaligned = (bus.jump_reg_target[1:0] != 2'b00);
    end else if (bus.jump) begin
      sel_tgt = j_tgt;
      non_seq = 1'b1;
    end else if (take_br) begin
      sel_tgt = br_tgt;
      non_seq = 1'b1;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    redirect_d = 1'b0;
    misalign_d = misalign_q;
    cnt_d      = cnt_q;
    if (!bus.stall) begin
      pc_d       = {sel_tgt[WIDTH-1:2], 2'b00};
      redirect_d = non_seq;
      misalign_d = misalign_q | jr_misaligned;
      // Saturate rather than wrap so software sees a lower bound on redirects.
      if (non_seq && (cnt_q != {CNT_WIDTH{1'b1}})) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_VECTOR;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.pc             = pc_q;
  assign bus.pc_plus4       = pc_plus4;
  assign bus.redirect       = redirect_q;
  assign bus.misalign_err   = misalign_q;
  assign bus.redirect_count = cnt_q;

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Registered program-counter stage of the single-cycle MIPS datapath.
- Generalises the 2:1 next-PC select (PC+4 vs branch target) into a prioritised 4-source select: sequential, conditional branch (beq/bne), jump, jump-register.
- Adds a stall hold, a sticky misalignment flag and a saturating taken-redirect counter.
- Feeds instruction memory and the PC+4 link path.

Parameters:
- WIDTH, 32, PC/address width in bits; legal range ≥ 28.
- RESET_VECTOR, 0, PC value loaded on reset; bits [1:0] must be 0.
- CNT_WIDTH, 16, width of redirect counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold PC, counter and flags this cycle
- branch_eq  input  1  beq decoded
- branch_ne  input  1  bne decoded
- zero  input  1  ALU zero flag
- jump  input  1  j/jal decoded
- jump_reg  input  1  jr/jalr decoded
- branch_offset  input  WIDTH  sign-extended word offset (imm16 extended)
- jump_index  input  26  instr[25:0]
- jump_reg_target  input  WIDTH  rs register value
- pc  output  WIDTH  current PC (register)
- pc_plus4  output  WIDTH  pc + 4, combinational, mod 2^WIDTH
- redirect  output  1  registered; 1 for one cycle after a non-sequential PC load
- misalign_err  output  1  sticky; set when a selected target has bits [1:0] ≠ 0
- redirect_count  output  CNT_WIDTH  saturating count of taken redirects

Behaviour:
- Reset: synchronous, active-high. On the rising edge with reset=1:
  - pc = RESET_VECTOR; redirect = 0; misalign_err = 0; redirect_count = 0.
  - reset overrides stall and all select inputs.
- Branch condition: take_br = (branch_eq & zero) | (branch_ne & ~zero).
- Targets, all arithmetic mod 2^WIDTH:
  - br_tgt = pc_plus4 + (branch_offset << 2), upper overflow bits dropped.
  - j_tgt = {pc_plus4[WIDTH-1:28], jump_index, 2'b00}; when WIDTH = 28 it is {jump_index, 2'b00}.
  - jr_tgt = jump_reg_target.
- Priority, fixed: jump_reg > jump > take_br > sequential. Lower-priority requests asserted in the same cycle are ignored.
- next_pc = selected target with bits [1:0] forced to 00.
- Misalignment: if the selected target is jr_tgt and jr_tgt[1:0] ≠ 0, misalign_err ← 1. It stays 1 until reset; the PC still loads the masked target.
- Normal edge (reset=0, stall=0):
  - pc ← next_pc.
  - redirect ← 1 iff a non-sequential source was selected, else 0.
  - redirect_count increments on the same condition and saturates at 2^CNT_WIDTH−1 (no wrap).
- Stall edge (reset=0, stall=1):
  - pc, redirect_count and misalign_err hold; redirect ← 0.
  - Select inputs are ignored, including branch/jump requests.
- Latency: pc updates one clock after the select inputs are sampled. pc_plus4 follows pc combinationally with zero latency.
- Wrap-around: pc = 2^WIDTH−4 with a sequential step → pc = 0; redirect stays 0.
- Reset mid-stall or mid-redirect: reset wins; redirect is 0 in the following cycle.
- No internal state other than pc, redirect, misalign_err and redirect_count.

Test Plan:
- Reset then 3 free-running clocks, no selects → pc 0x0, 0x4, 0x8, 0xC; redirect=0; redirect_count=0.
- pc=0x10, branch_eq=1, zero=1, branch_offset=0x3 → pc=0x20, redirect=1 for one cycle, count=1. Same with zero=0 → pc=0x14, redirect=0.
- pc=0x10, branch_ne=1, zero=0, branch_offset=0xFFFFFFFE (−2) → pc=0x0C.
- jump=1, jump_index=0x0000040, and branch_eq=1 with zero=1 in the same cycle → pc=0x00000100; jump wins.
- jump_reg=1 and jump=1 together, jump_reg_target=0x00400006 → pc=0x00400004, misalign_err=1, still 1 after a further 5 sequential cycles; cleared only by reset.
- Mixed stall, wrap and reset:
  - stall=1 with jump asserted → pc unchanged, redirect=0, count unchanged.
  - pc=0xFFFFFFFC sequential → pc=0x0.
  - reset and stall asserted together → pc=RESET_VECTOR.
  - CNT_WIDTH=2 with 5 redirects → count saturates at 3.
